// File: rtl/lsu_pkg.sv
// Types and constants shared by the LSU data-memory path and the memory instance.
package lsu_pkg;

  localparam int unsigned LdTagW     = 4;
  localparam int unsigned DMEM_BYTES = 256;

  typedef logic [LdTagW-1:0] ld_tag_t;

  typedef struct packed {
    ld_tag_t     tag;
    logic [31:0] data;
    logic        err;
  } dmem_rsp_t;

  typedef enum logic {
    ST_PRI,
    LD_PRI
  } arb_pri_e;

endpackage

// File: rtl/dmem_rsp_buf.sv
// One-entry registered response slice between the data memory and CDB arbitration.
module dmem_rsp_buf
  import lsu_pkg::*;
#(
  parameter int unsigned Width = $bits(dmem_rsp_t)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  // Accept when empty or when the held entry leaves this same cycle.
  assign in_ready_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between store commit and the load queue,
// with a starvation guard for loads and a one-entry registered load response.
module dmem_port_arbiter
  import lsu_pkg::*;
#(
  parameter int unsigned TAG_W        = LdTagW,
  parameter int unsigned MEM_BYTES    = DMEM_BYTES,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             st_valid_i,
  output logic             st_ready_o,
  input  logic [31:0]      st_addr_i,
  input  logic [31:0]      st_data_i,
  input  logic             ld_valid_i,
  output logic             ld_ready_o,
  input  logic [31:0]      ld_addr_i,
  input  logic [TAG_W-1:0] ld_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_err_o,
  output logic             st_err_o,
  output logic             mem_wr_en_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam int unsigned     CntW    = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned     RspW    = TAG_W + 33;
  localparam logic [32:0]     MaxAddr = 33'(MEM_BYTES - 4);
  localparam logic [CntW-1:0] Limit   = CntW'(STARVE_LIMIT);

  arb_pri_e        pri_q, pri_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            st_err_q;
  logic            rsp_free, ld_elig, st_gnt, ld_gnt, st_oor, ld_oor;
  logic [RspW-1:0] rsp_in, rsp_out;

  // 33-bit compare so addresses near 2^32 cannot wrap into range.
  function automatic logic out_of_range(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} > MaxAddr);
  endfunction

  assign st_oor  = out_of_range(st_addr_i);
  assign ld_oor  = out_of_range(ld_addr_i);
  assign ld_elig = ld_valid_i && rsp_free;

  // Grants are suppressed while reset is held so no write leaks out during reset.
  always_comb begin
    st_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (rst_ni) begin
      unique case (pri_q)
        LD_PRI: begin
          ld_gnt = ld_elig;
          st_gnt = st_valid_i && !ld_elig;
        end
        default: begin
          st_gnt = st_valid_i;
          ld_gnt = ld_elig && !st_valid_i;
        end
      endcase
    end
  end

  always_comb begin
    pri_d = pri_q;
    cnt_d = cnt_q;
    if (ld_gnt) begin
      cnt_d = '0;
      pri_d = ST_PRI;
    end else if (st_gnt && ld_elig && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == Limit) begin
        pri_d = LD_PRI;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pri_q    <= ST_PRI;
      cnt_q    <= '0;
      st_err_q <= 1'b0;
    end else begin
      pri_q    <= pri_d;
      cnt_q    <= cnt_d;
      st_err_q <= st_err_q || (st_gnt && st_oor);
    end
  end

  always_comb begin
    mem_wr_en_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    if (st_gnt) begin
      mem_wr_en_o = !st_oor;
      mem_addr_o  = st_addr_i;
      mem_data_o  = st_data_i;
    end else if (ld_gnt) begin
      mem_addr_o  = ld_addr_i;
    end
  end

  assign rsp_in = {ld_tag_i, (ld_oor ? 32'h0 : mem_rdata_i), ld_oor};

  dmem_rsp_buf #(
    .Width (RspW)
  ) u_rsp_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (ld_gnt),
    .in_ready_o  (rsp_free),
    .in_data_i   (rsp_in),
    .out_valid_o (rsp_valid_o),
    .out_ready_i (rsp_ready_i),
    .out_data_o  (rsp_out)
  );

  assign st_ready_o = st_gnt;
  assign ld_ready_o = ld_gnt;
  assign st_err_o   = st_err_q;
  assign rsp_tag_o  = rsp_out[RspW-1 -: TAG_W];
  assign rsp_data_o = rsp_out[32:1];
  assign rsp_err_o  = rsp_out[0];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of grants, memory contents and the response buffer.
module tb_dmem_port_arbiter;

  localparam int unsigned TAG_W        = 4;
  localparam int unsigned MEM_BYTES    = 256;
  localparam int unsigned STARVE_LIMIT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             st_valid_i, st_ready_o, ld_valid_i, ld_ready_o;
  logic [31:0]      st_addr_i, st_data_i, ld_addr_i;
  logic [TAG_W-1:0] ld_tag_i, rsp_tag_o;
  logic             rsp_valid_o, rsp_ready_i, rsp_err_o, st_err_o, mem_wr_en_o;
  logic [31:0]      rsp_data_o, mem_addr_o, mem_data_o, mem_rdata_i;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .TAG_W        (TAG_W),
    .MEM_BYTES    (MEM_BYTES),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .st_valid_i  (st_valid_i),
    .st_ready_o  (st_ready_o),
    .st_addr_i   (st_addr_i),
    .st_data_i   (st_data_i),
    .ld_valid_i  (ld_valid_i),
    .ld_ready_o  (ld_ready_o),
    .ld_addr_i   (ld_addr_i),
    .ld_tag_i    (ld_tag_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_tag_o   (rsp_tag_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .st_err_o    (st_err_o),
    .mem_wr_en_o (mem_wr_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Environment memory driven by the DUT's port.
  logic [31:0] mem [64] = '{default: '0};
  always @(posedge clk) if (mem_wr_en_o) mem[mem_addr_o[7:2]] <= mem_data_o;
  assign mem_rdata_i = mem[mem_addr_o[7:2]];

  // Reference model state.
  logic [31:0]      ref_mem [64] = '{default: '0};
  int               blocked;
  logic             r_valid, r_err, r_sterr;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_data;
  bit               st_done, ld_done;
  logic [66:0]      exp_comb, got_comb;
  int               checks = 0;
  int               errors = 0;

  wire [38:0] got_rsp = {rsp_valid_o, rsp_tag_o, rsp_data_o, rsp_err_o, st_err_o};
  wire [38:0] exp_rsp = {r_valid, r_tag, r_data, r_err, r_sterr};

  function automatic bit oor(input logic [31:0] a);
    longint unsigned v = 64'(a);
    return (v % 4 != 0) || (v + 4 > MEM_BYTES);
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'($urandom_range(0, 32'h10f));
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  task automatic model_reset();
    blocked = 0;
    r_valid = 0; r_err = 0; r_sterr = 0; r_tag = '0; r_data = '0;
    st_done = 0; ld_done = 0;
  endtask

  // One clock: predict and snapshot the combinational outputs, then advance the model.
  task automatic tick();
    bit elig, lw, sw;
    @(negedge clk);
    elig = ld_valid_i && (!r_valid || rsp_ready_i);
    lw   = elig && (!st_valid_i || blocked >= int'(STARVE_LIMIT));
    sw   = st_valid_i && !lw;
    if (sw)      exp_comb = {1'b1, 1'b0, !oor(st_addr_i), st_addr_i, st_data_i};
    else if (lw) exp_comb = {1'b0, 1'b1, 1'b0, ld_addr_i, 32'h0};
    else         exp_comb = '0;
    got_comb = {st_ready_o, ld_ready_o, mem_wr_en_o, mem_addr_o, mem_data_o};
    @(posedge clk);
    if (sw && !oor(st_addr_i)) ref_mem[st_addr_i[7:2]] = st_data_i;
    if (sw && oor(st_addr_i))  r_sterr = 1'b1;
    if (lw) begin
      r_valid = 1'b1;
      r_tag   = ld_tag_i;
      r_err   = oor(ld_addr_i);
      r_data  = r_err ? 32'h0 : ref_mem[ld_addr_i[7:2]];
      blocked = 0;
    end else begin
      if (rsp_ready_i) r_valid = 1'b0;
      if (sw && elig) blocked++;
    end
    st_done = sw;
    ld_done = lw;
    #1;
  endtask

  task automatic idle_inputs();
    st_valid_i = 0; ld_valid_i = 0; st_addr_i = '0; st_data_i = '0;
    ld_addr_i = '0; ld_tag_i = '0; rsp_ready_i = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    model_reset();
    #12;
    checks++;
    if (got_rsp !== 39'h0) begin
      errors++; $display("FAIL reset_rsp got=%h exp=0", got_rsp);
    end
    checks++;
    if ({st_ready_o, ld_ready_o, mem_wr_en_o, mem_addr_o} !== 35'h0) begin
      errors++; $display("FAIL reset_port got=%b%b%b %h exp=0", st_ready_o, ld_ready_o,
                         mem_wr_en_o, mem_addr_o);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
  endtask

  task automatic test_store_then_load();
    st_valid_i = 1; st_addr_i = 32'h10; st_data_i = 32'hdeadbeef;
    tick();
    checks++;
    if (got_comb !== exp_comb || !st_done) begin
      errors++; $display("FAIL stl_store got=%h exp=%h", got_comb, exp_comb);
    end
    st_valid_i = 0; ld_valid_i = 1; ld_addr_i = 32'h10; ld_tag_i = 4'd3;
    tick();
    checks++;
    if (got_comb !== exp_comb) begin
      errors++; $display("FAIL stl_load got=%h exp=%h", got_comb, exp_comb);
    end
    checks++;
    if ({rsp_valid_o, rsp_tag_o, rsp_data_o, rsp_err_o} !== {1'b1, 4'd3, 32'hdeadbeef, 1'b0}) begin
      errors++; $display("FAIL stl_rsp got=%h exp=%h", got_rsp, {1'b1, 4'd3, 32'hdeadbeef, 1'b0});
    end
    ld_valid_i = 0;
    tick();
  endtask

  task automatic test_starvation();
    st_valid_i = 1; st_addr_i = 32'h20; ld_valid_i = 1; ld_addr_i = 32'h10; ld_tag_i = 4'd5;
    rsp_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      st_data_i = $urandom;
      tick();
      checks++;
      if (got_comb !== exp_comb || got_comb[65] !== (i % 5 == 4)) begin
        errors++; $display("FAIL starve_c%0d got=%h exp=%h ld_gnt_exp=%0d", i, got_comb,
                           exp_comb, (i % 5 == 4));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    ld_valid_i = 1; ld_addr_i = 32'h10; ld_tag_i = 4'd6; rsp_ready_i = 1;
    tick();
    ld_addr_i = 32'h20; ld_tag_i = 4'd7; rsp_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (got_comb[65] !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'd6
          || got_rsp !== exp_rsp) begin
        errors++; $display("FAIL bp_stall%0d got=%h exp=%h ld_ready=%b", i, got_rsp, exp_rsp,
                           got_comb[65]);
      end
    end
    rsp_ready_i = 1;
    tick();
    checks++;
    if (got_comb[65] !== 1'b1 || rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'd7
        || got_rsp !== exp_rsp) begin
      errors++; $display("FAIL bp_drain_grant got=%h exp=%h ld_ready=%b", got_rsp, exp_rsp,
                         got_comb[65]);
    end
    ld_valid_i = 0;
    tick();
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_empty got=%b exp=0", rsp_valid_o);
    end
  endtask

  task automatic test_range_errors();
    st_valid_i = 1; st_addr_i = 32'hfd; st_data_i = 32'h12345678;
    tick();
    checks++;
    if (got_comb[66:64] !== 3'b100 || got_comb !== exp_comb) begin
      errors++; $display("FAIL rng_store got=%h exp=%h", got_comb, exp_comb);
    end
    checks++;
    if (st_err_o !== 1'b1 || mem[63] !== ref_mem[63]) begin
      errors++; $display("FAIL rng_sterr got=%b/%h exp=1/%h", st_err_o, mem[63], ref_mem[63]);
    end
    st_addr_i = 32'hfc; st_data_i = 32'hcafef00d;
    tick();
    st_valid_i = 0; ld_valid_i = 1; ld_addr_i = 32'h102; ld_tag_i = 4'd9;
    tick();
    checks++;
    if (rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0 || st_err_o !== 1'b1 || got_rsp !== exp_rsp) begin
      errors++; $display("FAIL rng_load got=%h exp=%h", got_rsp, exp_rsp);
    end
    ld_addr_i = 32'hfc; ld_tag_i = 4'd2;
    tick();
    checks++;
    if (rsp_data_o !== 32'hcafef00d || rsp_err_o !== 1'b0 || got_rsp !== exp_rsp) begin
      errors++; $display("FAIL rng_top_word got=%h exp=%h", got_rsp, exp_rsp);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_idle();
    st_valid_i = 1; ld_valid_i = 1; st_addr_i = 32'h30; ld_addr_i = 32'h30; ld_tag_i = 4'd1;
    repeat (2) begin
      st_data_i = $urandom;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (got_comb !== 67'h0 || got_comb !== exp_comb) begin
        errors++; $display("FAIL idle_c%0d got=%h exp=0", i, got_comb);
      end
    end
    st_valid_i = 1; ld_valid_i = 1; st_addr_i = 32'h30; ld_addr_i = 32'h30; ld_tag_i = 4'd1;
    for (int i = 0; i < 3; i++) begin
      st_data_i = $urandom;
      tick();
      checks++;
      if (got_comb[65] !== (i == 2) || got_comb !== exp_comb) begin
        errors++; $display("FAIL idle_resume%0d got=%h exp=%h", i, got_comb, exp_comb);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    idle_inputs();
    st_done = 0; ld_done = 0;
    for (int i = 0; i < 400; i++) begin
      if (!st_valid_i || st_done) begin
        st_valid_i = ($urandom_range(0, 2) != 0);
        st_addr_i  = rand_addr();
        st_data_i  = $urandom;
      end
      if (!ld_valid_i || ld_done) begin
        ld_valid_i = ($urandom_range(0, 2) != 0);
        ld_addr_i  = rand_addr();
        ld_tag_i   = 4'($urandom);
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (got_comb !== exp_comb) begin
        errors++; $display("FAIL rand_port%0d got=%h exp=%h", i, got_comb, exp_comb);
      end
      checks++;
      if (got_rsp !== exp_rsp) begin
        errors++; $display("FAIL rand_rsp%0d got=%h exp=%h", i, got_rsp, exp_rsp);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_op();
    int wr_seen = 0;
    ld_valid_i = 1; ld_addr_i = 32'h40; ld_tag_i = 4'ha; rsp_ready_i = 1;
    tick();
    ld_valid_i = 0; rsp_ready_i = 0;
    st_valid_i = 1; st_addr_i = 32'h44; st_data_i = 32'h5a5a5a5a;
    #2 rst_n = 0;
    #1;
    checks++;
    if (got_rsp !== 39'h0 || st_ready_o !== 1'b0 || mem_wr_en_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid got=%h st_ready=%b wr=%b exp=0", got_rsp, st_ready_o,
                         mem_wr_en_o);
    end
    repeat (3) begin
      @(negedge clk) if (mem_wr_en_o !== 1'b0) wr_seen++;
      @(posedge clk) #1 if (mem_wr_en_o !== 1'b0) wr_seen++;
    end
    checks++;
    if (wr_seen != 0 || mem[17] !== ref_mem[17]) begin
      errors++; $display("FAIL rst_no_write got=%0d/%h exp=0/%h", wr_seen, mem[17], ref_mem[17]);
    end
    model_reset();
    st_valid_i = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    st_valid_i = 1; rsp_ready_i = 1;
    tick();
    ld_valid_i = 1; ld_addr_i = 32'h44; ld_tag_i = 4'hb; st_valid_i = 0;
    tick();
    checks++;
    if (rsp_data_o !== 32'h5a5a5a5a || got_rsp !== exp_rsp) begin
      errors++; $display("FAIL rst_represent got=%h exp=%h", got_rsp, exp_rsp);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_store_then_load();
    test_starvation();
    test_backpressure();
    test_range_errors();
    test_idle();
    test_random();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
